// File: rtl/mem_access.sv
// Memory-access stage: turns EX/MEM load/store ops into single-beat data-bus
// transactions, formats load data and flags misaligned or timed-out accesses.
module mem_access #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_pc,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        mem_valid,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    output logic [7:0]  mem_aluop,
    output logic        mem_excp,
    output logic        stallreq
);
    localparam logic [7:0] OP_LB = 8'hE0, OP_LH = 8'hE1, OP_LW = 8'hE3, OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5, OP_SB = 8'hE8, OP_SH = 8'hE9, OP_SW = 8'hEB;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    op_q, op_d;
    logic [31:0]   addr_q, addr_d, sdata_q, sdata_d, pc_q, pc_d;
    logic [4:0]    wd_q, wd_d;

    logic          mem_valid_q, mem_valid_d, mem_wreg_q, mem_wreg_d, mem_excp_q, mem_excp_d;
    logic [4:0]    mem_wd_q, mem_wd_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d, mem_pc_q, mem_pc_d;
    logic [7:0]    mem_aluop_q, mem_aluop_d;

    logic          ex_is_mem, ex_misal, ex_go, timeout, op_load;
    logic [15:0]   lane;
    logic [31:0]   load_data, st_wdata;
    logic [3:0]    st_be;

    always_comb begin
        ex_is_mem = 1'b0;
        ex_misal  = 1'b0;
        case (ex_aluop)
            OP_LB, OP_LBU, OP_SB: ex_is_mem = 1'b1;
            OP_LH, OP_LHU, OP_SH: begin ex_is_mem = 1'b1; ex_misal = ex_mem_addr[0]; end
            OP_LW, OP_SW:         begin ex_is_mem = 1'b1; ex_misal = |ex_mem_addr[1:0]; end
            default: ;
        endcase
        ex_go = ex_valid & ex_is_mem & ~ex_misal;
    end

    // Captured op encoding: bit3 = store, bit2 = unsigned load, [1:0] = size.
    assign timeout = (state_q == BUSY) && (cnt_q == CW'(ACK_TIMEOUT));
    assign op_load = ~op_q[3];
    assign lane    = 16'(dbus_rdata >> {addr_q[1:0], 3'b000});

    always_comb begin
        case (op_q[1:0])
            2'b00: begin
                load_data = op_q[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
                st_be     = 4'b0001 << addr_q[1:0];
                st_wdata  = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                load_data = op_q[2] ? {16'h0, lane} : {{16{lane[15]}}, lane};
                st_be     = addr_q[1] ? 4'b1100 : 4'b0011;
                st_wdata  = {2{sdata_q[15:0]}};
            end
            default: begin
                load_data = dbus_rdata;
                st_be     = 4'b1111;
                st_wdata  = sdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A timeout wins over a late ack: the request is already withdrawn that cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (ex_go) begin
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: begin
                if (timeout || dbus_ack) state_d = IDLE;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dbus_req   = (state_q == BUSY) && !timeout;
        dbus_we    = dbus_req && !op_load;
        dbus_be    = dbus_req ? (op_load ? 4'b1111 : st_be) : 4'b0000;
        dbus_addr  = dbus_req ? {addr_q[31:2], 2'b00} : 32'h0;
        dbus_wdata = dbus_we ? st_wdata : 32'h0;
        stallreq   = rst && ((state_q == IDLE) ? ex_go : (!timeout && !dbus_ack));
    end

    always_comb begin
        op_d        = op_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        pc_d        = pc_q;
        wd_d        = wd_q;
        mem_valid_d = 1'b0;
        mem_wreg_d  = 1'b0;
        mem_excp_d  = 1'b0;
        mem_wd_d    = mem_wd_q;
        mem_wdata_d = mem_wdata_q;
        mem_pc_d    = mem_pc_q;
        mem_aluop_d = mem_aluop_q;
        if (state_q == IDLE) begin
            if (ex_go) begin
                op_d    = ex_aluop;
                addr_d  = ex_mem_addr;
                sdata_d = ex_reg2;
                pc_d    = ex_pc;
                wd_d    = ex_wd;
            end
            if (ex_valid && !ex_go) begin
                mem_valid_d = 1'b1;
                mem_wd_d    = ex_wd;
                mem_pc_d    = ex_pc;
                mem_aluop_d = ex_aluop;
                if (ex_misal) begin
                    mem_excp_d  = 1'b1;
                    mem_wdata_d = ex_mem_addr;
                end else begin
                    mem_wreg_d  = ex_wreg;
                    mem_wdata_d = ex_wdata;
                end
            end
        end else if (timeout || dbus_ack) begin
            mem_valid_d = 1'b1;
            mem_wd_d    = wd_q;
            mem_pc_d    = pc_q;
            mem_aluop_d = op_q;
            if (timeout) begin
                mem_excp_d  = 1'b1;
                mem_wdata_d = addr_q;
            end else begin
                mem_wreg_d  = op_load;
                mem_wdata_d = op_load ? load_data : sdata_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= '0; addr_q <= '0; sdata_q <= '0; pc_q <= '0; wd_q <= '0;
            mem_valid_q <= 1'b0; mem_wreg_q <= 1'b0; mem_excp_q <= 1'b0;
            mem_wd_q <= '0; mem_wdata_q <= '0; mem_pc_q <= '0; mem_aluop_q <= '0;
        end else begin
            op_q <= op_d; addr_q <= addr_d; sdata_q <= sdata_d; pc_q <= pc_d; wd_q <= wd_d;
            mem_valid_q <= mem_valid_d; mem_wreg_q <= mem_wreg_d; mem_excp_q <= mem_excp_d;
            mem_wd_q <= mem_wd_d; mem_wdata_q <= mem_wdata_d; mem_pc_q <= mem_pc_d;
            mem_aluop_q <= mem_aluop_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_wd    = mem_wd_q;
    assign mem_wreg  = mem_wreg_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_pc    = mem_pc_q;
    assign mem_aluop = mem_aluop_q;
    assign mem_excp  = mem_excp_q;
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: random instruction stream plus directed cases, with a
// transaction-level model that predicts each result, its stall count and bus beats.
module tb_mem_access;
    localparam int T = 16;

    logic        clk = 1'b0, rst = 1'b0;
    logic        ex_valid = 1'b0, ex_wreg = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic [31:0] ex_wdata = '0, ex_pc = '0, ex_mem_addr = '0, ex_reg2 = '0;
    logic [7:0]  ex_aluop = '0;
    logic        dbus_req, dbus_we, dbus_ack = 1'b0;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
    logic        mem_valid, mem_wreg, mem_excp, stallreq;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_pc;
    logic [7:0]  mem_aluop;

    mem_access #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_wdata(ex_wdata), .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
        .ex_reg2(ex_reg2), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
        .dbus_ack(dbus_ack), .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_aluop(mem_aluop), .mem_excp(mem_excp),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        valid, wreg, excp, chk_wdata;
        logic [4:0]  wd;
        logic [31:0] wdata, pc;
        logic [7:0]  aluop;
        int          exp_stalls, obs_stalls, exp_nreq, obs_nreq;
    } exp_t;

    exp_t        exq [0:1023];
    int          wr_idx = 0, rd_idx = 0, cyc = 0;
    int          n_tests = 0, n_fail = 0;
    logic        bus_act = 1'b0, bus_we = 1'b0;
    logic [3:0]  bus_be = '0;
    logic [31:0] bus_addr = '0, bus_wd = '0;
    logic [7:0]  memops [8] = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic m_is_mem(input logic [7:0] op);
        return op inside {8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB};
    endfunction
    function automatic logic m_is_store(input logic [7:0] op);
        return op inside {8'hE8, 8'hE9, 8'hEB};
    endfunction
    function automatic logic m_misal(input logic [7:0] op, input logic [31:0] a);
        if (op inside {8'hE1, 8'hE5, 8'hE9}) return a % 2 != 0;
        if (op inside {8'hE3, 8'hEB}) return a % 4 != 0;
        return 1'b0;
    endfunction
    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
        int sh;
        logic [7:0] b;
        logic [15:0] h;
        sh = 8 * int'(a % 4);
        b = 8'(rd >> sh);
        h = 16'(rd >> sh);
        case (op)
            8'hE0: return {{24{b[7]}}, b};
            8'hE4: return {24'h0, b};
            8'hE1: return {{16{h[15]}}, h};
            8'hE5: return {16'h0, h};
            default: return rd;
        endcase
    endfunction
    function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] a);
        if (op == 8'hE8) return 4'(1 << (a % 4));
        if (op == 8'hE9) return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction
    function automatic logic [31:0] m_bwd(input logic [7:0] op, input logic [31:0] d);
        if (op == 8'hE8) return {4{d[7:0]}};
        if (op == 8'hE9) return {2{d[15:0]}};
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req", 32'(dbus_req), 0);
            chk("rst_stall", 32'(stallreq), 0);
            chk("rst_we_be", {27'h0, dbus_we, dbus_be}, 0);
            chk("rst_mem_ctl", {29'h0, mem_valid, mem_wreg, mem_excp}, 0);
            chk("rst_mem_data", mem_wdata | mem_pc | {19'h0, mem_wd, mem_aluop}, 0);
        end else begin
            if (rd_idx < wr_idx && exq[rd_idx].due <= cyc) begin
                exp_t e;
                e = exq[rd_idx];
                rd_idx++;
                chk("due_cycle", e.due, cyc);
                chk("mem_valid", 32'(mem_valid), 32'(e.valid));
                if (e.valid) begin
                    chk("mem_wd", 32'(mem_wd), 32'(e.wd));
                    chk("mem_wreg", 32'(mem_wreg), 32'(e.wreg));
                    chk("mem_excp", 32'(mem_excp), 32'(e.excp));
                    chk("mem_pc", mem_pc, e.pc);
                    chk("mem_aluop", 32'(mem_aluop), 32'(e.aluop));
                    if (e.chk_wdata) chk("mem_wdata", mem_wdata, e.wdata);
                end else begin
                    chk("idle_wreg", 32'(mem_wreg), 0);
                    chk("idle_excp", 32'(mem_excp), 0);
                end
                chk("stall_cycles", e.obs_stalls, e.exp_stalls);
                chk("bus_beats", e.obs_nreq, e.exp_nreq);
            end else begin
                chk("stall_valid", 32'(mem_valid), 0);
            end
            if (dbus_req) begin
                chk("bus_expected", 32'(bus_act), 1);
                if (bus_act) begin
                    chk("dbus_we", 32'(dbus_we), 32'(bus_we));
                    chk("dbus_be", 32'(dbus_be), 32'(bus_be));
                    chk("dbus_addr", dbus_addr, bus_addr);
                    if (bus_we) chk("dbus_wdata", dbus_wdata, bus_wd);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // delay: BUSY cycles before ack (>= T withholds it). Literal fields override the model.
    task automatic run_instr(input logic v, input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] reg2, input logic [31:0] alu, input logic [31:0] pc,
                             input logic [4:0] wd, input logic wreg, input int delay,
                             input logic [31:0] rd, input logic spur, input logic lit_en,
                             input logic [31:0] lit_wdata, input int lit_stalls, input int lit_nreq,
                             input logic [3:0] lit_be, input logic [31:0] lit_baddr,
                             input logic [31:0] lit_bwd);
        exp_t e;
        logic go, done;
        go = v && m_is_mem(op) && !m_misal(op, addr);
        ex_valid = v; ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2;
        ex_wdata = alu; ex_pc = pc; ex_wd = wd; ex_wreg = wreg;
        e.valid = v; e.wd = wd; e.pc = pc; e.aluop = op; e.chk_wdata = 1'b1;
        e.wreg = 1'b0; e.excp = 1'b0; e.wdata = '0; e.exp_stalls = 0; e.exp_nreq = 0;
        if (v && !m_is_mem(op)) begin
            e.wreg = wreg; e.wdata = alu;
        end else if (v && !go) begin
            e.excp = 1'b1; e.wdata = addr;
        end else if (go && delay >= T) begin
            e.excp = 1'b1; e.chk_wdata = 1'b0; e.exp_stalls = T + 1; e.exp_nreq = T;
        end else if (go) begin
            e.wreg = !m_is_store(op);
            e.wdata = m_is_store(op) ? reg2 : m_load(op, addr, rd);
            e.exp_stalls = delay + 1; e.exp_nreq = delay + 1;
        end
        bus_act = go; bus_we = m_is_store(op); bus_be = m_be(op, addr);
        bus_addr = addr & 32'hFFFF_FFFC; bus_wd = m_bwd(op, reg2);
        if (lit_en) begin
            e.wdata = lit_wdata; e.exp_stalls = lit_stalls; e.exp_nreq = lit_nreq;
            bus_be = lit_be; bus_addr = lit_baddr; bus_wd = lit_bwd;
        end
        e.obs_stalls = 0; e.obs_nreq = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (dbus_req) begin
                e.obs_nreq++;
                if (e.obs_nreq == delay + 1) begin dbus_ack = 1'b1; dbus_rdata = rd; end
            end else if (spur && !go) begin
                dbus_ack = 1'b1;
            end
            #1;
            if (stallreq) e.obs_stalls++;
            else begin
                done = 1'b1;
                e.due = cyc + 1;
                exq[wr_idx] = e;
                wr_idx++;
            end
            @(posedge clk); #1;
            dbus_ack = 1'b0; dbus_rdata = $urandom;
        end
        if (!done) begin
            $display("FAIL stall_bound: stallreq still high after 40 cycles");
            e.obs_stalls = -1; e.due = cyc;
            exq[wr_idx] = e;
            wr_idx++;
        end
        bus_act = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // ADD, single-cycle passthrough
        run_instr(1, 8'h20, 32'h0, 32'h0, 32'h1234, 32'h1000, 5'd5, 1, 0, 0, 0,
                  1, 32'h1234, 0, 0, 4'h0, 32'h0, 32'h0);
        // LB / LBU at 0x103 with ack two cycles after the request
        run_instr(1, 8'hE0, 32'h103, 32'h0, 32'h0, 32'h1004, 5'd6, 1, 2, 32'h80AABBCC, 0,
                  1, 32'hFFFFFF80, 3, 3, 4'b1111, 32'h100, 32'h0);
        run_instr(1, 8'hE4, 32'h103, 32'h0, 32'h0, 32'h1008, 5'd7, 1, 2, 32'h80AABBCC, 0,
                  1, 32'h00000080, 3, 3, 4'b1111, 32'h100, 32'h0);
        // SH at 0x202, zero-wait bus
        run_instr(1, 8'hE9, 32'h202, 32'hDEADBEEF, 32'h0, 32'h100C, 5'd8, 1, 0, 0, 0,
                  1, 32'hDEADBEEF, 1, 1, 4'b1100, 32'h200, 32'hBEEFBEEF);
        // misaligned LW never reaches the bus
        run_instr(1, 8'hE3, 32'h102, 32'h0, 32'h0, 32'h1010, 5'd9, 1, 0, 0, 1,
                  1, 32'h102, 0, 0, 4'b1111, 32'h100, 32'h0);
        // withheld ack -> bus-error abort
        run_instr(1, 8'hE3, 32'h400, 32'h0, 32'h0, 32'h1014, 5'd10, 1, 99, 0, 0,
                  1, 32'h0, T + 1, T, 4'b1111, 32'h400, 32'h0);
        // idle slot with a spurious ack
        run_instr(0, 8'hE3, 32'h500, 32'h0, 32'h0, 32'h1018, 5'd11, 1, 0, 0, 1,
                  0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        // reset in the middle of a BUSY access
        ex_valid = 1'b1; ex_aluop = 8'hE3; ex_mem_addr = 32'h300; ex_pc = 32'h2000;
        bus_act = 1'b1; bus_we = 1'b0; bus_be = 4'b1111; bus_addr = 32'h300;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk); #2;
        bus_act = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        run_instr(1, 8'h33, 32'h0, 32'h0, 32'hCAFE0001, 32'h2004, 5'd3, 1, 0, 0, 0,
                  1, 32'hCAFE0001, 0, 0, 4'h0, 32'h0, 32'h0);

        // random instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [7:0] op;
            int d;
            if ($urandom_range(0, 2) != 0) op = memops[$urandom_range(0, 7)];
            else begin
                op = 8'($urandom);
                if (m_is_mem(op)) op = 8'h20;
            end
            d = ($urandom_range(0, 11) == 0) ? 99 : int'($urandom_range(0, 3));
            run_instr($urandom_range(0, 9) != 0, op, $urandom, $urandom, $urandom, $urandom,
                      5'($urandom), 1'($urandom), d, $urandom, 1'($urandom),
                      0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        end

        ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum BUSY cycles without dbus_ack before a bus-error abort.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ex_valid  input  1  EX/MEM slot holds a valid instruction.
REQ-005 ex_wd / ex_wreg / ex_wdata  input  5/1/32  dest reg, write flag, ALU result.
REQ-006 ex_pc / ex_aluop  input  32/8  instruction PC, operation code.
REQ-007 ex_mem_addr / ex_reg2  input  32/32  effective address, store data.
REQ-008 dbus_req / dbus_we / dbus_be  output  1/1/4  bus request, write, byte enables.
REQ-009 dbus_addr / dbus_wdata  output  32/32  word address ({addr[31:2],2'b00}), store data.
REQ-010 dbus_rdata / dbus_ack  input  32/1  read data, one-cycle completion strobe.
REQ-011 mem_valid / mem_wd / mem_wreg / mem_wdata  output  1/5/1/32  registered result to MEM/WB.
REQ-012 mem_pc / mem_aluop / mem_excp  output  32/8/1  passthrough PC, op, misalign/bus-error flag.
REQ-013 stallreq  output  1  hold EX/MEM and upstream stages.

Function
REQ-014 Memory ops SHALL be LB=8'hE0, LBU=8'hE4, LH=8'hE1, LHU=8'hE5, LW=8'hE3, SB=8'hE8, SH=8'hE9, SW=8'hEB; all other codes are non-memory.
REQ-015 FSM states SHALL be IDLE and BUSY only.
REQ-016 IDLE, ex_valid=1, non-memory op: next edge mem_* = ex_*, mem_valid=1, mem_excp=0; stallreq=0; latency 1.
REQ-017 IDLE, ex_valid=0: next edge mem_valid=0, mem_wreg=0, mem_excp=0.
REQ-018 IDLE, aligned memory op: stallreq=1 combinationally; next edge capture op/addr/data, enter BUSY, mem_valid=0.
REQ-019 Misaligned (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0): no bus access, stallreq=0, next edge mem_valid=1, mem_excp=1, mem_wreg=0, mem_wdata=ex_mem_addr.
REQ-020 BUSY: dbus_req=1 with dbus_we/be/addr/wdata stable until ack; stallreq=!dbus_ack; mem_valid=0 each non-ack cycle.
REQ-021 BUSY with dbus_ack=1: next edge return to IDLE, drop dbus_req, mem_valid=1, mem_excp=0; EX/MEM advances on the same edge.
REQ-022 Byte lanes little-endian: SB be=4'b0001<<addr[1:0], wdata={4{byte}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{half}}; SW be=4'b1111; loads be=4'b1111, dbus_we=0.
REQ-023 Loads: lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; mem_wreg=1, mem_wdata=formatted data.
REQ-024 Stores: mem_wreg=0 regardless of ex_wreg; mem_wdata=store data.
REQ-025 Cycle counter SHALL clear on BUSY entry; ACK_TIMEOUT BUSY cycles without ack: drop dbus_req, stallreq=0 that cycle, next edge IDLE, mem_valid=1, mem_excp=1, mem_wreg=0.
REQ-026 dbus_ack while IDLE SHALL be ignored.

Reset
REQ-027 rst=0 SHALL immediately force IDLE, counter=0, dbus_req=0, dbus_we=0, dbus_be=0, stallreq=0, all mem_* outputs 0, including mid-BUSY.
REQ-028 Zero-wait bus: memory op total latency 2 cycles (IDLE->BUSY, ack in first BUSY cycle).

Verification
REQ-029 ADD, ex_wdata=32'h1234, ex_wd=5 -> one edge later mem_valid=1, mem_wdata=32'h1234, mem_wd=5, stallreq never 1.
REQ-030 LB addr=32'h103, ack 2 cycles after req, rdata=32'h80AABBCC -> dbus_addr=32'h100, stallreq 3 cycles, mem_wdata=32'hFFFFFF80; LBU same -> 32'h00000080.
REQ-031 SH addr=32'h202, ex_reg2=32'hDEADBEEF, zero-wait ack -> dbus_we=1, be=4'b1100, wdata=32'hBEEFBEEF, mem_wreg=0.
REQ-032 LW addr=32'h102 -> no dbus_req, next edge mem_excp=1, mem_wreg=0, mem_wdata=32'h102.
REQ-033 LW, ack withheld (ACK_TIMEOUT=16) -> dbus_req drops after 16 BUSY cycles, mem_excp=1, return to IDLE.
REQ-034 rst=0 during BUSY -> dbus_req, stallreq, mem_valid=0 before next clock edge; after release, non-memory op completes in 1 cycle.
